// File: rtl/can_tx_serializer.sv
// CAN transmit serializer: waits for 11 recessive bit times, sends SOF plus a
// bit-stuffed payload pulled one bit at a time, and drops out on arbitration loss.
module can_tx_serializer #(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       can_rx,
  input  logic       tx_start,
  input  logic [6:0] tx_len,
  input  logic       tx_bit,
  output logic       bit_rd,
  output logic       can_tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       arb_lost,
  output logic [2:0] dbg_state
);

  localparam int BT       = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int IDLE_MAX = 11 * BT;
  localparam int CW       = $clog2(IDLE_MAX + 1);
  localparam int TW       = (BT > 1) ? $clog2(BT) : 1;

  localparam logic [CW-1:0] IDLE_MAX_C = CW'(IDLE_MAX);
  localparam logic [TW-1:0] BT_LAST    = TW'(BT - 1);
  localparam logic [TW-1:0] BT_HALF    = TW'(BT / 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_SOF   = 3'd2,
    S_DATA  = 3'd3,
    S_STUFF = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [6:0]      rem_q, rem_d;
  logic [2:0]      run_q, run_d;
  logic            last_q, last_d;
  logic            can_tx_q, can_tx_d;
  logic            bit_rd_q, bit_rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            arb_q, arb_d;
  logic            bus_idle;
  logic            lvl;

  assign bus_idle = (idle_cnt_q == IDLE_MAX_C);

  // Payload handshake: bit_rd is a one-clock pulse in the first clock of a
  // payload bit time; tx_bit must be valid in that clock and is consumed there.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rem_d      = rem_q;
    run_d      = run_q;
    last_d     = last_q;
    can_tx_d   = can_tx_q;
    busy_d     = busy_q;
    bit_rd_d   = 1'b0;
    done_d     = 1'b0;
    arb_d      = 1'b0;
    lvl        = 1'b1;
    idle_cnt_d = can_rx ? (bus_idle ? idle_cnt_q : idle_cnt_q + CW'(1)) : '0;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          busy_d  = 1'b1;
          rem_d   = tx_len;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (bus_idle) begin
          state_d = S_SOF;
          timer_d = '0;
        end
      end
      S_SOF, S_DATA, S_STUFF: begin
        timer_d = (timer_q == BT_LAST) ? '0 : timer_q + TW'(1);
        if (timer_q == '0) begin
          if (state_q == S_SOF)       lvl = 1'b0;
          else if (state_q == S_DATA) lvl = tx_bit;
          else                        lvl = ~last_q;
          can_tx_d = lvl;
          last_d   = lvl;
          // A stuff bit always differs from the previous level, so its run restarts at 1.
          run_d    = (state_q != S_SOF && lvl == last_q) ? run_q + 3'd1 : 3'd1;
          if (state_q == S_DATA) rem_d = rem_q - 7'd1;
        end
        if (state_q != S_SOF && timer_q == BT_HALF && can_tx_q && !can_rx) begin
          arb_d    = 1'b1;
          busy_d   = 1'b0;
          can_tx_d = 1'b1;
          timer_d  = '0;
          run_d    = '0;
          state_d  = S_IDLE;
        end else if (timer_q == BT_LAST) begin
          if (run_q == 3'd5) begin
            state_d = S_STUFF;
          end else if (rem_q != 7'd0) begin
            state_d  = S_DATA;
            bit_rd_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        can_tx_d = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        timer_d  = '0;
        run_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      timer_q    <= '0;
      rem_q      <= '0;
      run_q      <= '0;
      last_q     <= 1'b1;
      can_tx_q   <= 1'b1;
      bit_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      timer_q    <= timer_d;
      rem_q      <= rem_d;
      run_q      <= run_d;
      last_q     <= last_d;
      can_tx_q   <= can_tx_d;
      bit_rd_q   <= bit_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      arb_q      <= arb_d;
    end
  end

  assign can_tx    = can_tx_q;
  assign bit_rd    = bit_rd_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign arb_lost  = arb_q;
  assign dbg_state = state_q;

endmodule
